// File: rtl/reg_mux_n.sv
// Registered NCH:1 selector of WIDTH-bit channels with latched select, clear and range check.
// Latency: dout updates 1 cycle after en; no backpressure, every en cycle loads unconditionally.
module reg_mux_n #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    input  logic                 sel_ld,
    input  logic                 en,
    input  logic                 clr,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic [SELW-1:0]      sel_q,
    output logic                 sel_err
);

    logic [SELW-1:0]  sel_lat_q, sel_lat_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             sel_ok;
    logic [SELW-1:0]  sel_eff;
    logic [WIDTH-1:0] chan_sel;

    always_comb begin
        sel_ok  = (32'(sel) < NCH);
        // A legal select loaded this cycle is forwarded so sel_ld+en needs no extra cycle.
        sel_eff = (sel_ld && sel_ok) ? sel : sel_lat_q;

        chan_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_eff == SELW'(k)) begin
                chan_sel = in_bus[k*WIDTH +: WIDTH];
            end
        end

        sel_lat_d = sel_lat_q;
        if (sel_ld && sel_ok) begin
            sel_lat_d = sel;
        end
        err_d = sel_ld && !sel_ok;

        dout_d  = dout_q;
        valid_d = valid_q;
        if (clr) begin
            dout_d  = '0;
            valid_d = 1'b0;
        end else if (en) begin
            dout_d  = chan_sel;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_lat_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sel_lat_q <= sel_lat_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign sel_q      = sel_lat_q;
    assign sel_err    = err_q;

endmodule
